// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
// Carries the IR fields and ALU zero flag in, and every datapath enable and mux select out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM and ALU function decoder for the multicycle MIPS core.
// Per-state controls are registered alongside the state; write enables are gated by reset.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11,
    StBneEx   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic [2:0] alu_control;

  function automatic ctl_t decode(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      StFetch:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      StDecode:  c.alusrcb = 2'b11;
      StMemAdr:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      StMemRd:   c.iord = 1'b1;
      StMemWb:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      StMemWr:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      StRtypeEx: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      StRtypeWb: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      StBeqEx:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      StBneEx:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.bne = 1'b1; end
      StAddiEx:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      StAddiWb:  c.regwrite = 1'b1;
      StJEx:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpBne:      state_d = StBneEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // Controls are registered with the state so outputs come straight from flops.
  always_comb begin
    ctl_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctl_q   <= decode(StFetch);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    alu_control = 3'b010;
    case (ctl_q.aluop)
      2'b01: alu_control = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
      end
      default: alu_control = 3'b010;
    endcase
  end

  // Branch qualification uses the live zero flag; reset kills every write at once.
  assign bus.pcen = ~reset & (ctl_q.pcwrite | (ctl_q.branch & bus.zero) |
                              (ctl_q.bne & ~bus.zero));
  assign bus.memwrite   = ~reset & ctl_q.memwrite;
  assign bus.irwrite    = ~reset & ctl_q.irwrite;
  assign bus.regwrite   = ~reset & ctl_q.regwrite;
  assign bus.iord       = ctl_q.iord;
  assign bus.memtoreg   = ctl_q.memtoreg;
  assign bus.regdst     = ctl_q.regdst;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.pcsrc      = ctl_q.pcsrc;
  assign bus.alucontrol = alu_control;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model predicts the state
// walk and per-state outputs; directed literal checks pin the model on key cycles.
module tb_multicycle_controller;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  // Vector layout: pcen memwrite irwrite regwrite iord memtoreg regdst alusrca
  //                alusrcb[1:0] pcsrc[1:0] alucontrol[2:0] state[3:0]
  localparam logic [18:0] MaskPcen  = 19'h40000;
  localparam logic [18:0] MaskMw    = 19'h20000;
  localparam logic [18:0] MaskIrw   = 19'h10000;
  localparam logic [18:0] MaskRw    = 19'h08000;
  localparam logic [18:0] MaskIord  = 19'h04000;
  localparam logic [18:0] MaskM2r   = 19'h02000;
  localparam logic [18:0] MaskRdst  = 19'h01000;
  localparam logic [18:0] MaskPcsrc = 19'h00180;
  localparam logic [18:0] MaskAlu   = 19'h00070;
  localparam logic [18:0] MaskState = 19'h0000F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [18:0] exp_vec = '0;
  logic [18:0] lit_mask = '0;
  logic [18:0] lit_val = '0;
  string       lit_name = "";
  logic [18:0] dut_vec;

  assign dut_vec = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.memtoreg,
                    bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.state};

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Required outputs while the controller sits in state st.
  function automatic logic [18:0] model(input logic [3:0] st, input logic rst, input logic z,
                                        input logic [5:0] fn);
    logic pcen, mw, irw, rw, iord, m2r, rdst, asa;
    logic [1:0] asb, psrc;
    logic [2:0] alu;
    {pcen, mw, irw, rw, iord, m2r, rdst, asa} = '0;
    asb = 2'b00; psrc = 2'b00; alu = 3'b010;
    case (st)
      4'd0:  begin asb = 2'b01; irw = 1'b1; pcen = 1'b1; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; alu = r_alu(fn); end
      4'd7:  begin rdst = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; alu = 3'b110; psrc = 2'b01; pcen = z; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin psrc = 2'b10; pcen = 1'b1; end
      4'd12: begin asa = 1'b1; alu = 3'b110; psrc = 2'b01; pcen = ~z; end
      default: ;
    endcase
    if (rst) {pcen, mw, irw, rw} = '0;
    return {pcen, mw, irw, rw, iord, m2r, rdst, asa, asb, psrc, alu, st};
  endfunction

  function automatic int seq_len(input logic [5:0] o);
    case (o)
      OpLw:                   return 5;
      OpSw, OpR, OpAddi:      return 4;
      OpBeq, OpBne, OpJ:      return 3;
      default:                return 2;
    endcase
  endfunction

  function automatic logic [3:0] seq_state(input logic [5:0] o, input int i);
    logic [19:0] s;  // state walk, first state in the low nibble
    case (o)
      OpLw:    s = 20'h43210;
      OpSw:    s = 20'h05210;
      OpR:     s = 20'h07610;
      OpAddi:  s = 20'h0A910;
      OpBeq:   s = 20'h00810;
      OpBne:   s = 20'h00C10;
      OpJ:     s = 20'h00B10;
      default: s = 20'h00010;
    endcase
    return s[i*4 +: 4];
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ};
  endfunction

  // Single compare process: model vector every cycle, plus any pinned literals.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got %b required %b", $time, dut_vec, exp_vec);
      end
      if (lit_mask != '0) begin
        n_checks++;
        if ((dut_vec & lit_mask) !== lit_val) begin
          n_fail++;
          $display("FAIL%s: got %h required %h (mask %h)", lit_name, dut_vec & lit_mask,
                   lit_val, lit_mask);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] st, input logic rst, input logic [5:0] o,
                       input logic [5:0] fn, input logic z);
    @(posedge clk);
    #1;
    reset    = rst;
    bus.op   = o;
    bus.funct = fn;
    bus.zero = z;
    exp_vec  = model(st, rst, z, fn);
    lit_mask = '0;
    lit_val  = '0;
    lit_name = "";
    chk_en   = 1'b1;
    #1;
  endtask

  task automatic pin(input string nm, input logic [18:0] m, input logic [18:0] v);
    lit_mask = lit_mask | m;
    lit_val  = lit_val | (v & m);
    lit_name = {lit_name, " ", nm};
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input logic z,
                           input bit rnd_rst);
    int   n;
    bit   r;
    n = seq_len(o);
    for (int i = 0; i < n; i++) begin
      r = rnd_rst && ($urandom_range(0, 39) == 0);
      // IR still holds the previous instruction during fetch, so present junk there.
      if (i == 0 && rnd_rst) drive(seq_state(o, i), r, 6'($urandom), 6'($urandom), 1'($urandom));
      else drive(seq_state(o, i), r, o, fn, rnd_rst ? 1'($urandom) : z);
      if (r) begin
        repeat ($urandom_range(0, 2)) drive(4'd0, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
        break;
      end
    end
  endtask

  logic [5:0]  fn_tab  [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000};
  logic [18:0] alu_lit [5] = '{19'h60, 19'h00, 19'h10, 19'h70, 19'h20};

  initial begin
    logic [5:0] o, fn;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;

    drive(4'd0, 1'b1, OpLw, 6'd0, 1'b0);
    pin("reset_state", MaskState, 19'h0);
    pin("reset_enables", MaskPcen | MaskIrw | MaskMw | MaskRw, 19'h0);
    drive(4'd0, 1'b1, OpLw, 6'd0, 1'b0);

    // lw
    drive(4'd0, 1'b0, OpLw, 6'd0, 1'b0);
    pin("fetch_pcen_irwrite", MaskPcen | MaskIrw, MaskPcen | MaskIrw);
    drive(4'd1, 1'b0, OpLw, 6'd0, 1'b0);
    drive(4'd2, 1'b0, OpLw, 6'd0, 1'b0);
    drive(4'd3, 1'b0, OpLw, 6'd0, 1'b0);
    pin("lw_memrd", MaskIord | MaskState, MaskIord | 19'h3);
    drive(4'd4, 1'b0, OpLw, 6'd0, 1'b0);
    pin("lw_memwb", MaskRw | MaskM2r | MaskMw, MaskRw | MaskM2r);

    // sw
    for (int i = 0; i < 4; i++) drive(seq_state(OpSw, i), 1'b0, OpSw, 6'd0, 1'b0);
    pin("sw_memwr", MaskMw | MaskIord | MaskRw | MaskState, MaskMw | MaskIord | 19'h5);

    // addi
    for (int i = 0; i < 4; i++) drive(seq_state(OpAddi, i), 1'b0, OpAddi, 6'd0, 1'b0);
    pin("addi_wb", MaskRw | MaskRdst | MaskState, MaskRw | 19'hA);

    // R-type, each funct
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive(seq_state(OpR, i), 1'b0, OpR, fn_tab[k], 1'b0);
        if (i == 2) pin("r_alucontrol", MaskAlu, alu_lit[k]);
        if (i == 3) pin("r_wb", MaskRw | MaskRdst, MaskRw | MaskRdst);
      end
    end

    // beq / bne with both zero values
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 3; i++) drive(seq_state(OpBeq, i), 1'b0, OpBeq, 6'd0, 1'(z));
      pin("beq_ex", MaskPcen | MaskPcsrc | MaskAlu, (z == 1 ? MaskPcen : 19'h0) | 19'h80 | 19'h60);
      for (int i = 0; i < 3; i++) drive(seq_state(OpBne, i), 1'b0, OpBne, 6'd0, 1'(z));
      pin("bne_ex", MaskPcen | MaskPcsrc | MaskAlu, (z == 0 ? MaskPcen : 19'h0) | 19'h80 | 19'h60);
    end

    // j
    for (int i = 0; i < 3; i++) drive(seq_state(OpJ, i), 1'b0, OpJ, 6'd0, 1'b0);
    pin("j_ex", MaskPcen | MaskPcsrc, MaskPcen | 19'h100);

    // unknown opcode behaves as a two-cycle nop
    drive(4'd0, 1'b0, 6'b111111, 6'd0, 1'b0);
    drive(4'd1, 1'b0, 6'b111111, 6'd0, 1'b0);
    pin("nop_decode", MaskState | MaskPcen | MaskMw | MaskRw | MaskIrw, 19'h1);
    drive(4'd0, 1'b0, OpLw, 6'd0, 1'b0);
    pin("nop_back_to_fetch", MaskState, 19'h0);

    // reset while in MEMWR
    drive(4'd1, 1'b0, OpSw, 6'd0, 1'b0);
    drive(4'd2, 1'b0, OpSw, 6'd0, 1'b0);
    drive(4'd5, 1'b1, OpSw, 6'd0, 1'b0);
    pin("rst_memwr", MaskMw | MaskIord | MaskState, MaskIord | 19'h5);
    drive(4'd0, 1'b1, OpSw, 6'd0, 1'b0);
    pin("rst_held", MaskState | MaskIrw | MaskPcen, 19'h0);
    drive(4'd0, 1'b0, OpSw, 6'd0, 1'b0);
    pin("rst_release_fetch", MaskIrw | MaskPcen, MaskIrw | MaskPcen);
    for (int i = 1; i < 4; i++) drive(seq_state(OpSw, i), 1'b0, OpSw, 6'd0, 1'b0);

    // randomized instruction stream with sporadic resets
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: o = OpR;
        1: o = OpLw;
        2: o = OpSw;
        3: o = OpBeq;
        4: o = OpBne;
        5: o = OpAddi;
        6: o = OpJ;
        default: begin
          o = 6'($urandom);
          while (legal(o)) o = 6'($urandom);
        end
      endcase
      fn = ($urandom_range(0, 1) == 1) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      run_instr(o, fn, 1'b0, 1'b1);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
